// File: rtl/uart_clock_divider.sv
// Integer divider producing the UART bit-rate clock from the system clock.
// Output is a registered 50% square wave toggled by a half-period counter.
module uart_clock_divider #(
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 9600,
   parameter int HALF   = (BAUD > 0 && CLK_HZ / (2 * BAUD) >= 1)
                          ? CLK_HZ / (2 * BAUD) : 1,
   parameter int CW     = (HALF > 1) ? $clog2(HALF) : 1
) (
   input  logic clk,
   input  logic rst_l,
   output logic div_clk
);

   localparam logic [CW-1:0] LAST = CW'(HALF - 1);

   generate
      if (CLK_HZ <= 0 || BAUD <= 0 || BAUD > CLK_HZ / 2) begin : g_bad_rate
         $fatal(1, "uart_clock_divider: invalid CLK_HZ/BAUD");
      end
   endgenerate

   logic [CW-1:0] cnt;
   logic          div_q;

   // Counter wraps only at LAST; the wrap is the sole toggle point.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         cnt   <= '0;
         div_q <= 1'b0;
      end else if (cnt == LAST) begin
         cnt   <= '0;
         div_q <= ~div_q;
      end else begin
         cnt   <= cnt + 1'b1;
      end
   end

   assign div_clk = div_q;

endmodule

// File: tb/tb_uart_clock_divider.sv
// Directed bench for uart_clock_divider at HALF=4, HALF=1 and defaults.
module tb_uart_clock_divider;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b, rst_c;
   logic div_a, div_b, div_c;

   int checks = 0;
   int errors = 0;
   int maxc   = 0;

   uart_clock_divider #(.CLK_HZ(16), .BAUD(2)) dut_a (
      .clk(clk), .rst_l(rst_a), .div_clk(div_a)
   );
   uart_clock_divider #(.CLK_HZ(4), .BAUD(2)) dut_b (
      .clk(clk), .rst_l(rst_b), .div_clk(div_b)
   );
   uart_clock_divider dut_c (
      .clk(clk), .rst_l(rst_c), .div_clk(div_c)
   );

   always @(negedge clk)
      if (rst_c && int'(dut_c.cnt) > maxc) maxc = int'(dut_c.cnt);

   task automatic check(input string tag, input longint got,
                        input longint exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic dv(input int s);
      case (s)
         0: return div_a;
         1: return div_b;
         default: return div_c;
      endcase
   endfunction

   // Count clk edges until the selected div_clk goes 0->1.
   task automatic wait_rise(input int s, input int bound, output int n);
      logic prev;
      prev = dv(s);
      n = 0;
      while (n < bound) begin
         step();
         n++;
         if (!prev && dv(s)) return;
         prev = dv(s);
      end
      n = -1;
   endtask

   initial begin
      int rk, fk, hi, lo, n;
      logic [9:0] frame;
      rst_a = 1'b0;
      rst_b = 1'b0;
      rst_c = 1'b0;
      repeat (10) step();
      check("a_rst_div", div_a, 0);
      check("a_rst_cnt", dut_a.cnt, 0);
      check("c_rst_div", div_c, 0);

      // HALF=4: first rise at edge 4, fall at edge 8
      @(negedge clk) rst_a = 1'b1;
      rk = 0;
      fk = 0;
      for (int k = 1; k <= 8; k++) begin
         step();
         if (div_a && rk == 0) rk = k;
         if (!div_a && rk != 0 && fk == 0) fk = k;
      end
      check("a_first_rise", rk, 4);
      check("a_first_fall", fk, 8);

      for (int p = 0; p < 20; p++) begin
         hi = 0;
         lo = 0;
         for (int i = 0; i < 8; i++) begin
            if (div_a) hi++;
            else lo++;
            step();
         end
         check("a_high", hi, 4);
         check("a_low", lo, 4);
      end

      // now just after edge 168; edge 174 has div=1, cnt=2
      repeat (6) step();
      check("a_pre_div", div_a, 1);
      check("a_pre_cnt", dut_a.cnt, 2);
      rst_a = 1'b0;
      #1;
      check("a_async_div", div_a, 0);
      check("a_async_cnt", dut_a.cnt, 0);
      repeat (3) step();
      @(negedge clk) rst_a = 1'b1;
      wait_rise(0, 100, n);
      check("a_rerise", n, 4);

      // bit-serial frame clocked by div_clk: start, 0xA5 lsb first, stop
      frame = {1'b1, 8'hA5, 1'b0};
      for (int b = 0; b < 10; b++) begin
         wait_rise(0, 100, n);
         check($sformatf("tx_bit%0d_%0d", b, frame[b]), n, 8);
      end

      // HALF=1: toggles every edge
      @(negedge clk) rst_b = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         check($sformatf("b_edge%0d", k), div_b, k % 2);
      end

      // defaults: HALF=5208
      @(negedge clk) rst_c = 1'b1;
      wait_rise(2, 20000, n);
      check("c_first_rise", n, 5208);
      check("c_first_rise_ns", n * 10, 52080);
      wait_rise(2, 25000, n);
      check("c_period_ns", n * 10, 104160);
      check("c_cnt_max", maxc, 5207);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
